msi_cache_controller: RTL and testbench
=======================================

# msi_cache_controller

Parametrised MSI snooping coherence controller for a direct-mapped cache of NUM_LINES lines. It is the multi-line successor of the single-line CPU-side MSI state machine. It accepts CPU read/write requests, resolves hit/miss per line, and issues read-miss, write-miss or invalidate requests to the shared bus. It also applies incoming bus snoops to its own lines. It sits between one processor port and the snooping bus arbiter.

## Interface
- NUM_LINES, 4, number of cache lines; power of two, at least 2
- ADDR_W, 8, block address width; index = addr[IDX_W-1:0] with IDX_W = log2(NUM_LINES), tag = addr[ADDR_W-1:IDX_W]
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_write  in  1  0 = read, 1 = write
- cpu_req_addr  in  ADDR_W  block address
- cpu_req_ready  out  1  controller can accept a request
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_hit  out  1  request was a hit (valid with cpu_resp_valid)
- cpu_resp_state  out  2  final line state after the request
- bus_req_valid  out  1  bus request pending
- bus_req_cmd  out  2  read miss 00, write miss 01, invalidate 10
- bus_req_addr  out  ADDR_W  request address
- bus_req_wb  out  1  victim exclusive line must be written back first
- bus_grant  in  1  arbiter accepts the request this cycle
- snoop_valid  in  1  another cache's bus request is visible
- snoop_cmd  in  2  same encoding as bus_req_cmd
- snoop_addr  in  ADDR_W  snooped address
- snoop_flush  out  1  one-cycle pulse: this cache supplies/writes back an exclusive line

## Operation
- Line states: invalid 00, exclusive 01, shared 10. A line matches when its state is not invalid and its stored tag equals the request tag.
- FSM states: IDLE, LOOKUP, BUS, RESP.
- IDLE: cpu_req_ready=1. A request is accepted on valid&ready, captured, and the FSM moves to LOOKUP.
- LOOKUP decisions:
  - Read hit (shared or exclusive): no bus request.
  - Write hit on exclusive: no bus request.
  - Write hit on shared: cmd=invalidate.
  - Read miss: cmd=read miss.
  - Write miss: cmd=write miss.
  - bus_req_wb=1 only on a miss whose victim line is exclusive.
  - No-bus outcomes update the line and go to RESP. All others go to BUS.
- BUS: bus_req_valid=1 and all bus_req_* fields are held stable until the edge where bus_grant=1. At that edge:
  - The line takes the new tag.
  - State becomes shared after read miss, exclusive after write miss or invalidate.
  - The FSM moves to RESP.
- RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE.
- Snoops apply in any FSM state, to a matching line only:
  - Shared + read miss: stays shared.
  - Shared + write miss or invalidate: goes invalid.
  - Exclusive + read miss: goes shared, snoop_flush=1.
  - Exclusive + write miss: goes invalid, snoop_flush=1.
  - Non-matching snoops: no effect.

## Timing
- Reset values: FSM IDLE, all lines invalid with tag 0, cpu_req_ready=1, all other outputs 0.
- Hit latency: accept at edge E0, LOOKUP in the cycle after E0, cpu_resp_valid high in the cycle after E1. Next accept is possible at E3.
- Miss latency: bus_req_valid rises after E1. cpu_resp_valid is high in the cycle after the grant edge.
- snoop_flush is registered and rises the cycle after the snoop edge.
- Snoop to the captured index during LOOKUP: the FSM stays in LOOKUP one extra cycle and re-evaluates using the post-snoop state.
- Snoop invalidating the pending line while in BUS with cmd=invalidate: cmd becomes write miss on the next cycle and bus_req_valid stays high.
- bus_grant and a matching snoop on the same edge: the grant wins and the snoop is dropped. The arbiter must never produce this case.
- reset_n asserted mid-operation: immediate return to reset values, and any pending bus request is withdrawn.

## Configuration
- MSI_STATS_EN defined: adds 32-bit saturating outputs stat_hits, stat_misses and stat_snoop_inv.
  - stat_hits and stat_misses increment on each cpu_resp_valid.
  - stat_snoop_inv increments on each snoop that invalidates a line.
  - All three reset to 0.
- MSI_STATS_EN undefined: none of these ports or counters exist.

## Structure
- msi_pkg holds the line-state codes, bus command codes and FSM state encoding.
- Sub-module msi_line_store holds the per-line state and tag arrays with two update ports. Same-index same-edge priority is CPU over snoop; the FSM rules above make this unreachable except under the grant-priority rule.

## Test plan
- Parameters NUM_LINES=4, ADDR_W=8. Read 0x04 after reset -> bus cmd 00, wb=0. Grant -> resp hit=0, state 10.
- Write 0x04 after that -> cmd 10. Grant -> state 01. Second write 0x04 -> resp hit=1 with no bus request.
- Line 0x04 exclusive, read 0x08 (same index 0) -> cmd 00, wb=1.
- Line 0x04 exclusive, snoop read miss 0x04 -> snoop_flush pulse next cycle, line shared. Snoop write miss 0x04 -> line invalid.
- Write 0x04 on shared, hold bus_grant=0, snoop invalidate 0x04 -> cmd changes 10->01 on the next cycle. Grant -> state 01.
- Assert reset_n=0 while in BUS -> bus_req_valid drops immediately, all lines invalid.

Source files
------------

// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache controller: line states, bus commands,
// controller FSM states and the snoop state-transition helpers.
package msi_pkg;

    localparam logic [1:0] LINE_INV  = 2'b00;
    localparam logic [1:0] LINE_EXCL = 2'b01;
    localparam logic [1:0] LINE_SHRD = 2'b10;

    localparam logic [1:0] CMD_RD_MISS = 2'b00;
    localparam logic [1:0] CMD_WR_MISS = 2'b01;
    localparam logic [1:0] CMD_INVAL   = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_BUS    = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Next state of a matching line when another cache's request is snooped.
    // An invalidate seen on an exclusive line is not a legal MSI event; the
    // line is dropped without a flush. The unused command code is ignored.
    function automatic logic [1:0] snoop_next_state(input logic [1:0] cur, input logic [1:0] cmd);
        logic [1:0] nxt;
        nxt = cur;
        if (cur == LINE_SHRD && (cmd == CMD_WR_MISS || cmd == CMD_INVAL)) begin
            nxt = LINE_INV;
        end else if (cur == LINE_EXCL) begin
            if (cmd == CMD_RD_MISS) begin
                nxt = LINE_SHRD;
            end else if (cmd == CMD_WR_MISS || cmd == CMD_INVAL) begin
                nxt = LINE_INV;
            end
        end
        return nxt;
    endfunction

    // An exclusive line hit by a read or write miss must be supplied/written back.
    function automatic logic snoop_needs_flush(input logic [1:0] cur, input logic [1:0] cmd);
        return (cur == LINE_EXCL) && (cmd == CMD_RD_MISS || cmd == CMD_WR_MISS);
    endfunction

endpackage

// File: rtl/msi_line_store.sv
// Per-line state and tag arrays with one CPU-side and one snoop-side port.
// When both ports write the same index on the same edge the CPU write wins.
module msi_line_store
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] cpu_idx,
    output logic [1:0]       cpu_state,
    output logic [TAG_W-1:0] cpu_tag,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_wstate,
    input  logic [TAG_W-1:0] cpu_wtag,
    input  logic [IDX_W-1:0] snp_idx,
    output logic [1:0]       snp_state,
    output logic [TAG_W-1:0] snp_tag,
    input  logic             snp_we,
    input  logic [1:0]       snp_wstate
);

    logic [1:0]       state_q [NUM_LINES];
    logic [1:0]       state_d [NUM_LINES];
    logic [TAG_W-1:0] tag_q   [NUM_LINES];
    logic [TAG_W-1:0] tag_d   [NUM_LINES];

    assign cpu_state = state_q[cpu_idx];
    assign cpu_tag   = tag_q[cpu_idx];
    assign snp_state = state_q[snp_idx];
    assign snp_tag   = tag_q[snp_idx];

    // Merge both write ports; the CPU update is applied last so it takes priority.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        if (snp_we) begin
            state_d[snp_idx] = snp_wstate;
        end
        if (cpu_we) begin
            state_d[cpu_idx] = cpu_wstate;
            tag_d[cpu_idx]   = cpu_wtag;
        end
    end

    // Line array registers; reset leaves every line invalid with tag 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '{default: LINE_INV};
            tag_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/msi_cache_controller.sv
// MSI snooping coherence controller for a direct-mapped cache.
// Optional feature: define MSI_STATS_EN to add saturating 32-bit counters
// stat_hits, stat_misses and stat_snoop_inv.
module msi_cache_controller
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_write,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_hit,
    output logic [1:0]        cpu_resp_state,
    output logic              bus_req_valid,
    output logic [1:0]        bus_req_cmd,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_wb,
    input  logic              bus_grant,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_cmd,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_flush
`ifdef MSI_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_snoop_inv
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [1:0]        fsm_q, fsm_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              wb_q, wb_d;
    logic              hit_q, hit_d;
    logic [1:0]        rstate_q, rstate_d;
    logic              flush_q, flush_d;

    logic [IDX_W-1:0]  req_idx, snp_idx;
    logic [TAG_W-1:0]  req_tag, snp_tag_in;
    logic [1:0]        cur_state, snp_state, snp_next;
    logic [TAG_W-1:0]  cur_tag, snp_tag;
    logic              cpu_we, snp_we;
    logic [1:0]        cpu_wstate;
    logic              line_hit, snp_hit, snp_drop, snp_inv;

    assign req_idx    = addr_q[IDX_W-1:0];
    assign req_tag    = addr_q[ADDR_W-1:IDX_W];
    assign snp_idx    = snoop_addr[IDX_W-1:0];
    assign snp_tag_in = snoop_addr[ADDR_W-1:IDX_W];

    msi_line_store #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_idx   (req_idx),
        .cpu_state (cur_state),
        .cpu_tag   (cur_tag),
        .cpu_we    (cpu_we),
        .cpu_wstate(cpu_wstate),
        .cpu_wtag  (req_tag),
        .snp_idx   (snp_idx),
        .snp_state (snp_state),
        .snp_tag   (snp_tag),
        .snp_we    (snp_we),
        .snp_wstate(snp_next)
    );

    // Snoop evaluation; a snoop colliding with a grant on the same line is dropped.
    always_comb begin
        line_hit = (cur_state != LINE_INV) && (cur_tag == req_tag);
        snp_hit  = snoop_valid && (snp_state != LINE_INV) && (snp_tag == snp_tag_in);
        snp_drop = (fsm_q == ST_BUS) && bus_grant && (snp_idx == req_idx);
        snp_next = snoop_next_state(snp_state, snoop_cmd);
        snp_we   = snp_hit && !snp_drop && (snp_next != snp_state);
        snp_inv  = snp_we && (snp_next == LINE_INV);
        flush_d  = snp_hit && !snp_drop && snoop_needs_flush(snp_state, snoop_cmd);
    end

    // Request FSM: capture, look up, arbitrate for the bus, respond.
    always_comb begin
        fsm_d      = fsm_q;
        write_d    = write_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        wb_d       = wb_q;
        hit_d      = hit_q;
        rstate_d   = rstate_q;
        cpu_we     = 1'b0;
        cpu_wstate = (cmd_q == CMD_RD_MISS) ? LINE_SHRD : LINE_EXCL;
        case (fsm_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    write_d = cpu_req_write;
                    addr_d  = cpu_req_addr;
                    fsm_d   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                // A snoop to this index changes the line under us: re-evaluate next cycle.
                if (!(snoop_valid && snp_idx == req_idx)) begin
                    hit_d = line_hit;
                    if (line_hit && (!write_q || cur_state == LINE_EXCL)) begin
                        rstate_d = cur_state;
                        fsm_d    = ST_RESP;
                    end else begin
                        wb_d  = !line_hit && (cur_state == LINE_EXCL);
                        cmd_d = line_hit ? CMD_INVAL : (write_q ? CMD_WR_MISS : CMD_RD_MISS);
                        fsm_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (bus_grant) begin
                    cpu_we   = 1'b1;
                    rstate_d = cpu_wstate;
                    fsm_d    = ST_RESP;
                end else if (cmd_q == CMD_INVAL && snp_inv && snoop_addr == addr_q) begin
                    // Our shared copy was stolen before the upgrade won the bus.
                    cmd_d = CMD_WR_MISS;
                    hit_d = 1'b0;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q    <= ST_IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            cmd_q    <= CMD_RD_MISS;
            wb_q     <= 1'b0;
            hit_q    <= 1'b0;
            rstate_q <= LINE_INV;
            flush_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            wb_q     <= wb_d;
            hit_q    <= hit_d;
            rstate_q <= rstate_d;
            flush_q  <= flush_d;
        end
    end

    assign cpu_req_ready  = (fsm_q == ST_IDLE);
    assign cpu_resp_valid = (fsm_q == ST_RESP);
    assign cpu_resp_hit   = cpu_resp_valid && hit_q;
    assign cpu_resp_state = cpu_resp_valid ? rstate_q : LINE_INV;
    assign bus_req_valid  = (fsm_q == ST_BUS);
    assign bus_req_cmd    = bus_req_valid ? cmd_q : CMD_RD_MISS;
    assign bus_req_addr   = bus_req_valid ? addr_q : '0;
    assign bus_req_wb     = bus_req_valid && wb_q;
    assign snoop_flush    = flush_q;

`ifdef MSI_STATS_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d, sinv_q, sinv_d;

    // Saturating event counters.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        sinv_d   = sinv_q;
        if (cpu_resp_valid && hit_q && hits_q != '1) begin
            hits_d = hits_q + 32'd1;
        end
        if (cpu_resp_valid && !hit_q && misses_q != '1) begin
            misses_d = misses_q + 32'd1;
        end
        if (snp_inv && sinv_q != '1) begin
            sinv_d = sinv_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            sinv_q   <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            sinv_q   <= sinv_d;
        end
    end

    assign stat_hits      = hits_q;
    assign stat_misses    = misses_q;
    assign stat_snoop_inv = sinv_q;
`endif

endmodule

// File: tb/tb_msi_cache_controller.sv
// Self-checking bench for msi_cache_controller (NUM_LINES=4, ADDR_W=8):
// directed scenarios followed by random CPU requests and snoops, all
// checked against an array-based model of the MSI line rules.
module tb_msi_cache_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req_valid = 1'b0;
    logic       cpu_req_write = 1'b0;
    logic [7:0] cpu_req_addr = '0;
    logic       cpu_req_ready;
    logic       cpu_resp_valid;
    logic       cpu_resp_hit;
    logic [1:0] cpu_resp_state;
    logic       bus_req_valid;
    logic [1:0] bus_req_cmd;
    logic [7:0] bus_req_addr;
    logic       bus_req_wb;
    logic       bus_grant = 1'b0;
    logic       snoop_valid = 1'b0;
    logic [1:0] snoop_cmd = '0;
    logic [7:0] snoop_addr = '0;
    logic       snoop_flush;

    int checks = 0;
    int errors = 0;

    // Model: state per line (0 invalid, 1 exclusive, 2 shared) and stored tag.
    logic [1:0] mst  [4];
    logic [5:0] mtag [4];

    msi_cache_controller #(.NUM_LINES(4), .ADDR_W(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_write (cpu_req_write),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_ready (cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_hit  (cpu_resp_hit),
        .cpu_resp_state(cpu_resp_state),
        .bus_req_valid (bus_req_valid),
        .bus_req_cmd   (bus_req_cmd),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wb    (bus_req_wb),
        .bus_grant     (bus_grant),
        .snoop_valid   (snoop_valid),
        .snoop_cmd     (snoop_cmd),
        .snoop_addr    (snoop_addr),
        .snoop_flush   (snoop_flush)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mst[i]  = 2'd0;
            mtag[i] = 6'd0;
        end
    endtask

    // One complete CPU transaction from IDLE, granting after gdelay cycles.
    task automatic cpu_op(input logic wr, input logic [7:0] a, input int gdelay);
        logic [1:0] idx;
        logic [5:0] tg;
        logic       hit, need_bus, ewb;
        logic [1:0] ecmd, efinal;
        idx = a[1:0];
        tg  = a[7:2];
        hit = (mst[idx] != 2'd0) && (mtag[idx] == tg);
        ewb = 1'b0;
        ecmd = 2'd0;
        if (hit && (!wr || mst[idx] == 2'd1)) begin
            need_bus = 1'b0;
            efinal   = mst[idx];
        end else begin
            need_bus = 1'b1;
            ewb      = !hit && (mst[idx] == 2'd1);
            ecmd     = hit ? 2'd2 : (wr ? 2'd1 : 2'd0);
            efinal   = (ecmd == 2'd0) ? 2'd2 : 2'd1;
        end
        chk("ready_idle", cpu_req_ready, 1);
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = a;
        tick();
        cpu_req_valid = 1'b0;
        chk("ready_lookup", cpu_req_ready, 0);
        tick();
        if (need_bus) begin
            chk("bus_valid", bus_req_valid, 1);
            chk("bus_cmd", bus_req_cmd, ecmd);
            chk("bus_addr", bus_req_addr, a);
            chk("bus_wb", bus_req_wb, ewb);
            chk("resp_early", cpu_resp_valid, 0);
            for (int i = 0; i < gdelay; i++) begin
                tick();
                chk("bus_hold_valid", bus_req_valid, 1);
                chk("bus_hold_cmd", bus_req_cmd, ecmd);
                chk("bus_hold_addr", bus_req_addr, a);
                chk("bus_hold_wb", bus_req_wb, ewb);
            end
            bus_grant = 1'b1;
            tick();
            bus_grant = 1'b0;
            mst[idx]  = efinal;
            mtag[idx] = tg;
        end else begin
            chk("no_bus", bus_req_valid, 0);
        end
        chk("resp_valid", cpu_resp_valid, 1);
        chk("resp_hit", cpu_resp_hit, hit);
        chk("resp_state", cpu_resp_state, efinal);
        chk("bus_after_resp", bus_req_valid, 0);
        tick();
        chk("resp_pulse", cpu_resp_valid, 0);
        chk("ready_again", cpu_req_ready, 1);
    endtask

    // One snoop while the controller is idle.
    task automatic snoop_op(input logic [1:0] c, input logic [7:0] a);
        logic [1:0] idx;
        logic       match, eflush;
        idx    = a[1:0];
        match  = (mst[idx] != 2'd0) && (mtag[idx] == a[7:2]);
        eflush = 1'b0;
        if (match) begin
            if (mst[idx] == 2'd1) begin
                eflush   = 1'b1;
                mst[idx] = (c == 2'd0) ? 2'd2 : 2'd0;
            end else if (c != 2'd0) begin
                mst[idx] = 2'd0;
            end
        end
        snoop_valid = 1'b1;
        snoop_cmd   = c;
        snoop_addr  = a;
        tick();
        snoop_valid = 1'b0;
        chk("snoop_flush", snoop_flush, eflush);
        tick();
        chk("snoop_flush_pulse", snoop_flush, 0);
    endtask

    initial begin
        logic [1:0] rc;
        logic [7:0] ra;
        model_reset();
        repeat (2) tick();
        chk("rst_ready", cpu_req_ready, 1);
        chk("rst_resp", cpu_resp_valid, 0);
        chk("rst_hit", cpu_resp_hit, 0);
        chk("rst_state", cpu_resp_state, 0);
        chk("rst_bus", bus_req_valid, 0);
        chk("rst_cmd", bus_req_cmd, 0);
        chk("rst_addr", bus_req_addr, 0);
        chk("rst_wb", bus_req_wb, 0);
        chk("rst_flush", snoop_flush, 0);
        reset_n = 1'b1;
        tick();

        // Basic read miss, upgrade, write hit, victim write-back.
        cpu_op(1'b0, 8'h04, 2);
        cpu_op(1'b1, 8'h04, 1);
        cpu_op(1'b1, 8'h04, 0);
        cpu_op(1'b0, 8'h08, 0);
        cpu_op(1'b1, 8'h04, 0);
        snoop_op(2'd0, 8'h04);
        snoop_op(2'd1, 8'h04);
        cpu_op(1'b0, 8'h04, 0);

        // Upgrade loses its shared copy while waiting for the bus.
        cpu_req_valid = 1'b1;
        cpu_req_write = 1'b1;
        cpu_req_addr  = 8'h04;
        tick();
        cpu_req_valid = 1'b0;
        tick();
        chk("upg_cmd", bus_req_cmd, 2);
        snoop_valid = 1'b1;
        snoop_cmd   = 2'd2;
        snoop_addr  = 8'h04;
        tick();
        snoop_valid = 1'b0;
        chk("upg_conv_valid", bus_req_valid, 1);
        chk("upg_conv_cmd", bus_req_cmd, 1);
        chk("upg_conv_flush", snoop_flush, 0);
        tick();
        chk("upg_conv_hold", bus_req_cmd, 1);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        chk("upg_resp_valid", cpu_resp_valid, 1);
        chk("upg_resp_hit", cpu_resp_hit, 0);
        chk("upg_resp_state", cpu_resp_state, 1);
        tick();
        mst[0]  = 2'd1;
        mtag[0] = 6'd1;

        // Snoop to the captured index during lookup forces a re-evaluation.
        snoop_op(2'd0, 8'h04);
        cpu_req_valid = 1'b1;
        cpu_req_write = 1'b0;
        cpu_req_addr  = 8'h04;
        tick();
        cpu_req_valid = 1'b0;
        snoop_valid   = 1'b1;
        snoop_cmd     = 2'd1;
        snoop_addr    = 8'h04;
        tick();
        snoop_valid = 1'b0;
        chk("lk_stall_bus", bus_req_valid, 0);
        chk("lk_stall_resp", cpu_resp_valid, 0);
        tick();
        chk("lk_bus_valid", bus_req_valid, 1);
        chk("lk_bus_cmd", bus_req_cmd, 0);
        chk("lk_bus_wb", bus_req_wb, 0);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        chk("lk_resp_hit", cpu_resp_hit, 0);
        chk("lk_resp_state", cpu_resp_state, 2);
        tick();
        mst[0]  = 2'd2;
        mtag[0] = 6'd1;

        // Randomized requests and snoops over a small address pool.
        for (int n = 0; n < 150; n++) begin
            ra = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                rc = 2'($urandom_range(0, 2));
                if (rc == 2'd2 && mst[ra[1:0]] == 2'd1 && mtag[ra[1:0]] == ra[7:2]) begin
                    rc = 2'd0;
                end
                snoop_op(rc, ra);
            end else begin
                cpu_op(1'($urandom_range(0, 1)), ra, int'($urandom_range(0, 3)));
            end
        end

        // Reset while a bus request is pending.
        cpu_op(1'b1, 8'h04, 0);
        cpu_req_valid = 1'b1;
        cpu_req_write = 1'b1;
        cpu_req_addr  = 8'h08;
        tick();
        cpu_req_valid = 1'b0;
        tick();
        chk("pre_rst_bus", bus_req_valid, 1);
        chk("pre_rst_wb", bus_req_wb, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus", bus_req_valid, 0);
        chk("mid_rst_ready", cpu_req_ready, 1);
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        cpu_op(1'b0, 8'h04, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
